// File: rtl/vending_machine_acc_if.sv
// Purpose : bus bundle between the coin/select front-end and the
//           multi-item vending controller.
// Ports   : master drives coin/sel/sel_valid/cancel and observes results;
//           slave (the controller) does the reverse.
interface vending_machine_acc_if #(
  parameter int unsigned N_ITEMS  = 3,
  parameter int unsigned CREDIT_W = 8
);
  localparam int unsigned SW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

  logic [1:0]          coin;
  logic [SW-1:0]       sel;
  logic                sel_valid;
  logic                cancel;
  logic [N_ITEMS-1:0]  dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic [CREDIT_W-1:0] credit;
  logic [1:0]          err;
  logic                coin_reject;
  logic                busy;

  modport master (
    output coin, sel, sel_valid, cancel,
    input  dispense, change_valid, change, credit, err, coin_reject, busy
  );

  modport slave (
    input  coin, sel, sel_valid, cancel,
    output dispense, change_valid, change, credit, err, coin_reject, busy
  );
endinterface

// File: rtl/vending_machine_acc.sv
// Purpose : multi-coin, multi-item vending controller. Accumulates credit,
//           checks select requests against stock and price, dispenses one
//           item for one cycle, then returns change for one cycle.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-low reset
//           bus  - slave side of vending_machine_acc_if (coin, sel,
//                  sel_valid, cancel in; dispense, change_valid, change,
//                  credit, err, coin_reject, busy out; all outputs registered)
module vending_machine_acc #(
  parameter int unsigned                  N_ITEMS     = 3,
  parameter int unsigned                  CREDIT_W    = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0]  ITEM_PRICES = {8'd20, 8'd10, 8'd5},
  parameter int unsigned                  COIN1_VAL   = 5,
  parameter int unsigned                  COIN2_VAL   = 10,
  parameter int unsigned                  COIN3_VAL   = 20,
  parameter int unsigned                  MAX_CREDIT  = 255,
  parameter int unsigned                  STOCK_W     = 4,
  parameter int unsigned                  STOCK_INIT  = 2
) (
  input logic                 clk,
  input logic                 rst,
  vending_machine_acc_if.slave bus
);
  localparam int unsigned SW    = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam int unsigned SUM_W = CREDIT_W + 1;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SEL     = 2'b01;
  localparam logic [1:0] ERR_SOLDOUT = 2'b10;
  localparam logic [1:0] ERR_CREDIT  = 2'b11;

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] change_q;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [N_ITEMS-1:0]  disp_q;
  logic                cv_q;
  logic                busy_q;
  logic [1:0]          err_q;
  logic                rej_q;

  logic [SUM_W-1:0]    coin_val;
  logic [SUM_W-1:0]    coin_sum;
  logic                coin_fits;
  logic                coin_any;
  logic                sel_ok;
  logic [CREDIT_W-1:0] price_sel;
  logic [STOCK_W-1:0]  stock_sel;
  logic [N_ITEMS-1:0]  sel_onehot;

  // Coin decode and ceiling check; the extra bit keeps the sum from wrapping.
  always_comb begin
    coin_val = '0;
    case (bus.coin)
      2'b01:   coin_val = SUM_W'(COIN1_VAL);
      2'b10:   coin_val = SUM_W'(COIN2_VAL);
      2'b11:   coin_val = SUM_W'(COIN3_VAL);
      default: coin_val = '0;
    endcase
    coin_sum  = {1'b0, credit_q} + coin_val;
    coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));
    coin_any  = (bus.coin != 2'b00);
  end

  // Price/stock lookup for the selected item; out-of-range sel reads zero.
  always_comb begin
    price_sel  = '0;
    stock_sel  = '0;
    sel_ok     = (32'(bus.sel) < N_ITEMS);
    sel_onehot = N_ITEMS'(1) << bus.sel;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (bus.sel == SW'(i)) begin
        price_sel = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
        stock_sel = stock_q[i];
      end
    end
  end

  // Controller FSM with registered outputs and pulse flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      disp_q   <= '0;
      cv_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= ERR_NONE;
      rej_q    <= 1'b0;
      for (int i = 0; i < int'(N_ITEMS); i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      err_q  <= ERR_NONE;
      rej_q  <= 1'b0;
      disp_q <= '0;
      cv_q   <= 1'b0;
      busy_q <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (bus.cancel) begin
            // Cancel wins; a coin in the same cycle is refused.
            rej_q <= coin_any;
            if (credit_q != '0) begin
              change_q <= credit_q;
              credit_q <= '0;
              cv_q     <= 1'b1;
              busy_q   <= 1'b1;
              state    <= CHANGE;
            end
          end else if (bus.sel_valid) begin
            rej_q <= coin_any;
            if (!sel_ok)                   err_q <= ERR_SEL;
            else if (stock_sel == '0)      err_q <= ERR_SOLDOUT;
            else if (credit_q < price_sel) err_q <= ERR_CREDIT;
            else begin
              change_q <= credit_q - price_sel;
              credit_q <= '0;
              for (int i = 0; i < int'(N_ITEMS); i++) begin
                if (bus.sel == SW'(i)) stock_q[i] <= stock_sel - STOCK_W'(1);
              end
              disp_q <= sel_onehot;
              busy_q <= 1'b1;
              state  <= DISPENSE;
            end
          end else if (coin_any) begin
            if (coin_fits) begin
              credit_q <= CREDIT_W'(coin_sum);
              state    <= COLLECT;
            end else begin
              rej_q <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          rej_q <= coin_any;
          if (change_q != '0) begin
            cv_q   <= 1'b1;
            busy_q <= 1'b1;
            state  <= CHANGE;
          end else begin
            state <= IDLE;
          end
        end
        CHANGE: begin
          rej_q    <= coin_any;
          change_q <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dispense     = disp_q;
  assign bus.change_valid = cv_q;
  assign bus.change       = change_q;
  assign bus.credit       = credit_q;
  assign bus.err          = err_q;
  assign bus.coin_reject  = rej_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vending_machine_acc.sv
// Purpose : self-checking bench for vending_machine_acc. Directed scenarios
//           plus randomized traffic compared against a transaction-level
//           reference model; a second instance exercises a low credit ceiling.
// Ports   : none (top-level bench).
module tb_vending_machine_acc;
  localparam int unsigned N_ITEMS  = 3;
  localparam int unsigned CREDIT_W = 8;
  localparam int          MAXC     = 255;
  localparam int          SINIT    = 2;

  typedef struct {
    int disp;
    int cv;
    int chg;
    int busy;
  } out_t;

  localparam out_t IDLE_OUT = '{0, 0, 0, 0};

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vending_machine_acc_if #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W)) b ();
  vending_machine_acc_if #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W)) b40 ();

  vending_machine_acc #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  vending_machine_acc #(.N_ITEMS(N_ITEMS), .CREDIT_W(CREDIT_W), .MAX_CREDIT(40)) u_dut40 (
    .clk (clk),
    .rst (rst),
    .bus (b40.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credit, stock and a queue of upcoming busy-cycle outputs.
  int   m_credit;
  int   m_stock [N_ITEMS];
  int   m_err;
  int   m_rej;
  out_t cur;
  out_t pend [$];

  function automatic int price(int i);
    case (i)
      0:       return 5;
      1:       return 10;
      default: return 20;
    endcase
  endfunction

  function automatic int coin_value(logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 20;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int s;
    int ch;
    m_err = 0;
    m_rej = 0;
    s = int'(b.sel);
    if (!rst) begin
      m_credit = 0;
      foreach (m_stock[i]) m_stock[i] = SINIT;
      cur = IDLE_OUT;
      pend.delete();
    end else if (cur.busy != 0) begin
      m_rej = (b.coin != 2'b00) ? 1 : 0;
      if (pend.size() > 0) cur = pend.pop_front();
      else                 cur = IDLE_OUT;
    end else if (b.cancel) begin
      m_rej = (b.coin != 2'b00) ? 1 : 0;
      if (m_credit > 0) begin
        cur      = '{0, 1, m_credit, 1};
        m_credit = 0;
      end
    end else if (b.sel_valid) begin
      m_rej = (b.coin != 2'b00) ? 1 : 0;
      if (s >= int'(N_ITEMS))          m_err = 1;
      else if (m_stock[s] == 0)        m_err = 2;
      else if (m_credit < price(s))    m_err = 3;
      else begin
        ch = m_credit - price(s);
        m_stock[s] -= 1;
        m_credit = 0;
        cur = '{1 << s, 0, ch, 1};
        if (ch > 0) pend.push_back('{0, 1, ch, 1});
      end
    end else if (b.coin != 2'b00) begin
      if (m_credit + coin_value(b.coin) <= MAXC) m_credit += coin_value(b.coin);
      else                                       m_rej = 1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("credit",       32'(b.credit),       m_credit);
    chk("dispense",     32'(b.dispense),     cur.disp);
    chk("change_valid", 32'(b.change_valid), cur.cv);
    chk("change",       32'(b.change),       cur.chg);
    chk("busy",         32'(b.busy),         cur.busy);
    chk("err",          32'(b.err),          m_err);
    chk("coin_reject",  32'(b.coin_reject),  m_rej);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic step(logic [1:0] c, logic [1:0] s, logic sv, logic cn);
    b.coin      = c;
    b.sel       = s;
    b.sel_valid = sv;
    b.cancel    = cn;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    b40.coin = 2'b00; b40.sel = '0; b40.sel_valid = 1'b0; b40.cancel = 1'b0;

    // Reset state
    step(2'b00, 2'd0, 1'b0, 1'b0);
    chk("rst_credit", 32'(b.credit), 0);
    chk("rst_dispense", 32'(b.dispense), 0);
    rst = 1'b1;

    // Exact payment for item0
    step(2'b01, 2'd0, 1'b0, 1'b0);
    chk("t1_credit", 32'(b.credit), 5);
    step(2'b00, 2'd0, 1'b1, 1'b0);
    chk("t1_disp", 32'(b.dispense), 1);
    step(2'b00, 2'd0, 1'b0, 1'b0);
    chk("t1_no_change", 32'(b.change_valid), 0);

    // Overpay item0, change 15
    step(2'b11, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd0, 1'b1, 1'b0);
    step(2'b00, 2'd0, 1'b0, 1'b0);
    chk("t2_change", 32'(b.change), 15);
    step(2'b00, 2'd0, 1'b0, 1'b0);

    // Accumulate then cancel
    step(2'b10, 2'd0, 1'b0, 1'b0);
    step(2'b01, 2'd0, 1'b0, 1'b0);
    chk("t3_credit", 32'(b.credit), 15);
    step(2'b00, 2'd0, 1'b0, 1'b1);
    chk("t3_refund", 32'(b.change), 15);
    step(2'b00, 2'd0, 1'b0, 1'b0);

    // Insufficient credit, invalid sel, then buy item2
    step(2'b01, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd2, 1'b1, 1'b0);
    chk("t4_err_credit", 32'(b.err), 3);
    step(2'b00, 2'd3, 1'b1, 1'b0);
    chk("t4_err_sel", 32'(b.err), 1);
    step(2'b11, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd2, 1'b1, 1'b0);
    chk("t4_disp", 32'(b.dispense), 4);
    step(2'b00, 2'd0, 1'b0, 1'b0);
    chk("t4_change", 32'(b.change), 5);
    step(2'b00, 2'd0, 1'b0, 1'b0);

    // Sell out item1
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 2'd0, 1'b0, 1'b0);
      step(2'b00, 2'd1, 1'b1, 1'b0);
      step(2'b00, 2'd0, 1'b0, 1'b0);
    end
    chk("t5_soldout_credit", 32'(b.credit), 10);
    step(2'b00, 2'd1, 1'b1, 1'b0);
    chk("t5_soldout_err", 32'(b.err), 2);
    step(2'b00, 2'd0, 1'b0, 1'b1);
    step(2'b00, 2'd0, 1'b0, 1'b0);

    // Low ceiling instance: third 20-coin is refused
    b40.coin = 2'b11;
    tick();
    chk("m40_c1", 32'(b40.credit), 20);
    tick();
    chk("m40_c2", 32'(b40.credit), 40);
    chk("m40_rej0", 32'(b40.coin_reject), 0);
    tick();
    chk("m40_c3", 32'(b40.credit), 40);
    chk("m40_rej1", 32'(b40.coin_reject), 1);
    b40.coin = 2'b00;
    tick();
    chk("m40_rej_clear", 32'(b40.coin_reject), 0);

    // Reset in the middle of a dispense, then stock is back to two
    step(2'b11, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd2, 1'b1, 1'b0);
    chk("t6_disp", 32'(b.dispense), 4);
    rst = 1'b0;
    step(2'b00, 2'd0, 1'b0, 1'b0);
    chk("t6_rst_disp", 32'(b.dispense), 0);
    chk("t6_rst_cv", 32'(b.change_valid), 0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(2'b11, 2'd0, 1'b0, 1'b0);
      step(2'b00, 2'd2, 1'b1, 1'b0);
      chk("t6_restock_disp", 32'(b.dispense), 4);
      step(2'b00, 2'd0, 1'b0, 1'b0);
    end
    step(2'b11, 2'd0, 1'b0, 1'b0);
    step(2'b00, 2'd2, 1'b1, 1'b0);
    chk("t6_soldout", 32'(b.err), 2);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 63) != 0);
      step(($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
